// File: rtl/network_driver.sv
// Host-side inference sequencer for `network`: accepts one sample, clears and runs the
// bitstream, captures the result. Optional sample counter under NETWORK_DRIVER_COUNT_EN.
module network_driver #(
    parameter int INPUT_SIZE  = 2,
    parameter int OUTPUT_SIZE = 1,
    parameter int STREAM_LEN  = 256,
    parameter int CAPTURE_LAT = 1,
    parameter int MAX_VAL     = 255
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [32*INPUT_SIZE-1:0]  in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [32*OUTPUT_SIZE-1:0] out_data,
    output logic [32*INPUT_SIZE-1:0]  net_input,
    output logic                      net_n_rst,
    output logic                      net_compute,
`ifdef NETWORK_DRIVER_COUNT_EN
    output logic [15:0]               sample_count,
`endif
    input  logic [32*OUTPUT_SIZE-1:0] net_output
);

    localparam int CW = $clog2(STREAM_LEN + 1);
    localparam int LW = (CAPTURE_LAT > 1) ? $clog2(CAPTURE_LAT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        CAPTURE,
        WAIT,
        DONE
    } state_t;

    state_t                    state, next_state;
    logic                      started;
    logic [CW-1:0]             run_cnt;
    logic [LW-1:0]             lat_cnt;
    logic                      accept;
    logic                      capture_en;
    logic [32*INPUT_SIZE-1:0]  clamped;

    function automatic logic [31:0] clamp(input logic signed [31:0] v);
        if (v < 0)
            return 32'd0;
        else if (v > MAX_VAL)
            return 32'(MAX_VAL);
        else
            return v;
    endfunction

    always_comb begin
        clamped = '0;
        for (int i = 0; i < INPUT_SIZE; i++)
            clamped[32*i +: 32] = clamp(in_data[32*i +: 32]);
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        next_state  = state;
        in_ready    = started && (state == IDLE);
        out_valid   = (state == DONE);
        net_n_rst   = started && (state != CLEAR);
        net_compute = (state == CAPTURE);
        accept      = in_ready && in_valid;
        capture_en  = 1'b0;
        case (state)
            IDLE:    if (accept) next_state = CLEAR;
            CLEAR:   next_state = RUN;
            RUN:     if (run_cnt == CW'(STREAM_LEN - 1)) next_state = CAPTURE;
            CAPTURE: begin
                if (CAPTURE_LAT == 0) begin
                    next_state = DONE;
                    capture_en = 1'b1;
                end else begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == LW'(CAPTURE_LAT - 1)) begin
                    next_state = DONE;
                    capture_en = 1'b1;
                end
            end
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            started   <= 1'b0;
            run_cnt   <= '0;
            lat_cnt   <= '0;
            net_input <= '0;
            out_data  <= '0;
        end else begin
            state   <= next_state;
            started <= 1'b1;
            if (state == CLEAR)
                run_cnt <= '0;
            else if (state == RUN)
                run_cnt <= run_cnt + 1'b1;
            if (state == CAPTURE)
                lat_cnt <= '0;
            else if (state == WAIT)
                lat_cnt <= lat_cnt + 1'b1;
            if (accept)
                net_input <= clamped;
            if (capture_en)
                out_data <= net_output;
        end
    end

`ifdef NETWORK_DRIVER_COUNT_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            sample_count <= '0;
        else if (out_valid && out_ready)
            sample_count <= sample_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_network_driver.sv
// Directed, table-driven bench for network_driver (STREAM_LEN=16, CAPTURE_LAT=1), plus a
// second instance with CAPTURE_LAT=0 for the short-latency case.
module tb_network_driver;

    localparam int SL = 16;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_data;
    logic [31:0] out_data, net_output;
    logic [63:0] net_input;
    logic        net_n_rst, net_compute;

    logic        in_valid0, in_ready0, out_valid0, out_ready0;
    logic [31:0] out_data0;
    logic [63:0] net_input0;
    logic        net_n_rst0, net_compute0;
`ifdef NETWORK_DRIVER_COUNT_EN
    logic [15:0] sample_count, sample_count0;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    network_driver #(.STREAM_LEN(SL), .CAPTURE_LAT(1)) dut (
        .clk(clk), .n_rst(n_rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .net_input(net_input), .net_n_rst(net_n_rst), .net_compute(net_compute),
`ifdef NETWORK_DRIVER_COUNT_EN
        .sample_count(sample_count),
`endif
        .net_output(net_output)
    );

    network_driver #(.STREAM_LEN(SL), .CAPTURE_LAT(0)) dut0 (
        .clk(clk), .n_rst(n_rst),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .net_input(net_input0), .net_n_rst(net_n_rst0), .net_compute(net_compute0),
`ifdef NETWORK_DRIVER_COUNT_EN
        .sample_count(sample_count0),
`endif
        .net_output(net_output)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic signed [31:0] a0, a1;
        logic [31:0]        nout;
        logic [31:0]        e0, e1;
        int                 hold;
        bit                 keep;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One full transaction on dut; assumes we are at a negedge with the driver in IDLE.
    task automatic run_txn(input vec_t v);
        logic [63:0] exp_in;
        int e0, rlow, ccount, cj, vj, viol, hold_bad;
        bit seen;
        exp_in = {v.e1, v.e0};
        in_data = {v.a1, v.a0};
        net_output = v.nout;
        out_ready = 1'b0;
        in_valid = 1'b1;
        check("idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        e0 = cyc;
        in_valid = v.keep;
        rlow = 0; ccount = 0; cj = -1; vj = -1; viol = 0; seen = 1'b0;
        for (int j = 0; j < 100 && !seen; j++) begin
            if (j > 0) @(negedge clk);
            if (v.keep) begin
                if (in_ready || net_input !== exp_in) viol++;
                in_data = {$urandom, $urandom};
            end
            if (!net_n_rst) rlow++;
            if (net_compute) begin
                ccount++;
                cj = j;
            end
            if (out_valid) begin
                seen = 1'b1;
                vj = cyc - e0;
            end
        end
        check("out_valid_timeout", 64'(seen), 64'd1);
        check("net_input", net_input, exp_in);
        check("latency", 64'(vj), 64'(SL + 3));
        check("net_n_rst_low_cycles", 64'(rlow), 64'd1);
        check("compute_pulses", 64'(ccount), 64'd1);
        check("compute_end_edge", 64'(cj + 1), 64'(SL + 2));
        check("out_data", 64'(out_data), 64'(v.nout));
        if (v.keep) check("busy_ignores_in_valid", 64'(viol), 64'd0);
        if (v.hold > 0) begin
            net_output = ~v.nout;
            hold_bad = 0;
            for (int h = 0; h < v.hold; h++) begin
                @(negedge clk);
                if (!out_valid || out_data !== v.nout) hold_bad++;
            end
            check("done_hold", 64'(hold_bad), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_hs", 64'(out_valid), 64'd0);
        check("in_ready_after_hs", 64'(in_ready), 64'd1);
        check("net_input_held", net_input, exp_in);
        in_valid = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        vec_t extra;
        int bad, vj0;
        bit seen0;
        vecs[0] = '{a0: 100, a1: 50, nout: 32'd7, e0: 100, e1: 50, hold: 0, keep: 0};
        vecs[1] = '{a0: 300, a1: -7, nout: 32'd42, e0: 255, e1: 0, hold: 0, keep: 0};
        vecs[2] = '{a0: 255, a1: 256, nout: 32'd99, e0: 255, e1: 255, hold: 10, keep: 0};
        vecs[3] = '{a0: -1, a1: 0, nout: 32'd123, e0: 0, e1: 0, hold: 0, keep: 1};
        vecs[4] = '{a0: 32'sh7fffffff, a1: 32'sh80000000, nout: 32'd5, e0: 255, e1: 0, hold: 0, keep: 0};
        vecs[5] = '{a0: 254, a1: 1, nout: 32'hdeadbeef, e0: 254, e1: 1, hold: 3, keep: 0};

        n_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0;
        in_data = '0; net_output = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_net_input", net_input, 64'd0);
        check("rst_net_n_rst", 64'(net_n_rst), 64'd0);
        check("rst_net_compute", 64'(net_compute), 64'd0);
        n_rst = 1'b1;
        #1;
        check("in_ready_before_edge", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("in_ready_after_edge", 64'(in_ready), 64'd1);
        check("net_n_rst_idle", 64'(net_n_rst), 64'd1);

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Reset during RUN at count 5: everything drops at once, nothing completes.
        in_data = {32'd20, 32'd10};
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_net_input", net_input, 64'd0);
        check("midrst_net_n_rst", 64'(net_n_rst), 64'd0);
        check("midrst_compute", 64'(net_compute), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
`ifdef NETWORK_DRIVER_COUNT_EN
        check("midrst_count", 64'(sample_count), 64'd0);
`endif
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid || net_compute) bad++;
        end
        check("midrst_no_result", 64'(bad), 64'd0);
        extra = '{a0: 77, a1: 400, nout: 32'd11, e0: 77, e1: 255, hold: 0, keep: 0};
        run_txn(extra);

`ifdef NETWORK_DRIVER_COUNT_EN
        check("count_one", 64'(sample_count), 64'd1);
        run_txn(vecs[0]);
        run_txn(vecs[1]);
        check("count_three", 64'(sample_count), 64'd3);
        force dut.sample_count = 16'hFFFF;
        #1;
        release dut.sample_count;
        @(negedge clk);
        run_txn(vecs[0]);
        check("count_wrap", 64'(sample_count), 64'd0);
`endif

        // CAPTURE_LAT=0 instance: result is one edge earlier.
        in_data = {32'd3, 32'd4};
        net_output = 32'd55;
        in_valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid0 = 1'b0;
        vj0 = -1;
        seen0 = 1'b0;
        for (int j = 1; j < 100 && !seen0; j++) begin
            @(negedge clk);
            if (out_valid0) begin
                seen0 = 1'b1;
                vj0 = j;
            end
        end
        check("lat0_timeout", 64'(seen0), 64'd1);
        check("lat0_latency", 64'(vj0), 64'(SL + 2));
        check("lat0_out_data", 64'(out_data0), 64'd55);
        check("lat0_net_input", net_input0, {32'd3, 32'd4});
        out_ready0 = 1'b1;
        @(negedge clk);
        out_ready0 = 1'b0;
        check("lat0_after_hs", 64'({out_valid0, in_ready0}), 64'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
